// File: rtl/tcdm_slave_port_arbiter.sv
// ----------------------------------------------------------------------------
// tcdm_slave_port_arbiter
//   Round-robin arbiter sharing one TCDM slave port between NR_MASTER_PORTS
//   requesters. One request is forwarded per cycle. The granted master's id
//   is remembered so that the 1-cycle response is steered back to it. Per-
//   master wait counters report starvation while the slave stalls.
//
// Ports
//   clk_i, rst_i          : clock, synchronous active-high reset
//   m_req_i .. m_be_i     : per-master request channel (packed per master)
//   m_gnt_o               : per-master grant (combinational)
//   m_r_valid_o           : per-master response valid (combinational)
//   m_r_rdata_o, m_r_opc_o: response data / error, broadcast to all masters
//   s_req_o .. s_be_o     : request channel to the slave (combinational)
//   s_gnt_i               : slave grant
//   s_r_valid_i/rdata/opc : slave response, one cycle after the handshake
//   starve_o              : registered, wait counter i >= STARVE_THRESH
//   resp_err_o            : registered sticky, response with nothing pending
// ----------------------------------------------------------------------------
module tcdm_slave_port_arbiter #(
  parameter int NR_MASTER_PORTS = 4,
  parameter int STARVE_THRESH   = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_MASTER_PORTS-1:0]       m_req_i,
  input  logic [NR_MASTER_PORTS-1:0][31:0] m_add_i,
  input  logic [NR_MASTER_PORTS-1:0]       m_wen_i,
  input  logic [NR_MASTER_PORTS-1:0][31:0] m_wdata_i,
  input  logic [NR_MASTER_PORTS-1:0][3:0]  m_be_i,
  output logic [NR_MASTER_PORTS-1:0]       m_gnt_o,
  output logic [NR_MASTER_PORTS-1:0]       m_r_valid_o,
  output logic [31:0]                      m_r_rdata_o,
  output logic                             m_r_opc_o,
  output logic                             s_req_o,
  output logic [31:0]                      s_add_o,
  output logic                             s_wen_o,
  output logic [31:0]                      s_wdata_o,
  output logic [3:0]                       s_be_o,
  input  logic                             s_gnt_i,
  input  logic                             s_r_valid_i,
  input  logic [31:0]                      s_r_rdata_i,
  input  logic                             s_r_opc_i,
  output logic [NR_MASTER_PORTS-1:0]       starve_o,
  output logic                             resp_err_o
);

  localparam int              IDW     = $clog2(NR_MASTER_PORTS);
  localparam logic [IDW-1:0]  LAST_ID = IDW'(NR_MASTER_PORTS - 1);
  localparam logic [7:0]      THRESH  = 8'(STARVE_THRESH);

  // Next priority pointer: the master after 'id', wrapping at the last port.
  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] id);
    if (id == LAST_ID) begin
      ptr_after = {IDW{1'b0}};
    end else begin
      ptr_after = id + IDW'(1);
    end
  endfunction

  logic [IDW-1:0]             rr_ptr_r;
  logic                       pend_valid_r;
  logic [IDW-1:0]             pend_id_r;
  logic [7:0]                 wait_cnt_r [NR_MASTER_PORTS];
  logic [NR_MASTER_PORTS-1:0] starve_r;
  logic                       resp_err_r;

  logic [IDW-1:0]             sel_s;
  logic                       found_s;
  int                         idx_s;
  logic                       s_req_s;
  logic                       hs_s;

  // Reset masks the whole request side so nothing is granted while in reset.
  assign s_req_s = ~rst_i & (|m_req_i);
  assign hs_s    = s_req_s & s_gnt_i;

  // Round-robin search: first requesting index at or above rr_ptr, wrapping.
  always_comb begin
    sel_s   = rr_ptr_r;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NR_MASTER_PORTS; k++) begin
      idx_s = (int'(rr_ptr_r) + k) % NR_MASTER_PORTS;
      if (!found_s && m_req_i[idx_s]) begin
        sel_s   = IDW'(idx_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Request payload mux and grant steering toward the selected master.
  always_comb begin
    s_add_o   = 32'h0000_0000;
    s_wen_o   = 1'b0;
    s_wdata_o = 32'h0000_0000;
    s_be_o    = 4'b0000;
    m_gnt_o   = {NR_MASTER_PORTS{1'b0}};
    if (s_req_s) begin
      s_add_o   = m_add_i[sel_s];
      s_wen_o   = m_wen_i[sel_s];
      s_wdata_o = m_wdata_i[sel_s];
      s_be_o    = m_be_i[sel_s];
      if (s_gnt_i) begin
        m_gnt_o[sel_s] = 1'b1;
      end else begin
        m_gnt_o = {NR_MASTER_PORTS{1'b0}};
      end
    end else begin
      m_gnt_o = {NR_MASTER_PORTS{1'b0}};
    end
  end

  // Response steering: only the master recorded at the handshake sees valid.
  always_comb begin
    m_r_valid_o = {NR_MASTER_PORTS{1'b0}};
    if (!rst_i && pend_valid_r && s_r_valid_i) begin
      m_r_valid_o[pend_id_r] = 1'b1;
    end else begin
      m_r_valid_o = {NR_MASTER_PORTS{1'b0}};
    end
  end

  assign s_req_o     = s_req_s;
  assign m_r_rdata_o = s_r_rdata_i;
  assign m_r_opc_o   = s_r_opc_i;
  assign starve_o    = starve_r;
  assign resp_err_o  = resp_err_r;

  // Priority pointer and pending-response bookkeeping; a stall holds both.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_r     <= {IDW{1'b0}};
      pend_valid_r <= 1'b0;
      pend_id_r    <= {IDW{1'b0}};
    end else begin
      pend_valid_r <= hs_s;
      if (hs_s) begin
        rr_ptr_r  <= ptr_after(sel_s);
        pend_id_r <= sel_s;
      end else begin
        rr_ptr_r  <= rr_ptr_r;
        pend_id_r <= pend_id_r;
      end
    end
  end

  // Saturating wait counters and the registered starvation flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_MASTER_PORTS; i++) begin
        wait_cnt_r[i] <= 8'h00;
      end
      starve_r <= {NR_MASTER_PORTS{1'b0}};
    end else begin
      for (int i = 0; i < NR_MASTER_PORTS; i++) begin
        starve_r[i] <= (wait_cnt_r[i] >= THRESH);
        if (!m_req_i[i] || m_gnt_o[i]) begin
          wait_cnt_r[i] <= 8'h00;
        end else if (wait_cnt_r[i] != 8'hFF) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + 8'h01;
        end else begin
          wait_cnt_r[i] <= wait_cnt_r[i];
        end
      end
    end
  end

  // Sticky flag for a slave response that matches no outstanding transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_err_r <= 1'b0;
    end else if (s_r_valid_i && !pend_valid_r) begin
      resp_err_r <= 1'b1;
    end else begin
      resp_err_r <= resp_err_r;
    end
  end

endmodule

// File: doc/tcdm_slave_port_arbiter.md
# tcdm_slave_port_arbiter

Round-robin arbiter that shares one TCDM slave port (memory bank, peripheral bridge or error responder) between `NR_MASTER_PORTS` requesters, in front of a single output port of the SoC interconnect crossbar. It grants one request per cycle with a rotating priority pointer. It remembers which master was granted so that the 1-cycle response (read data and `opc`, writes included) is steered back to it. Per-master wait counters flag starvation when the downstream port stalls.

## Interface
- `NR_MASTER_PORTS`, default 4: number of requesters; legal range 2..16.
- `STARVE_THRESH`, default 64: wait cycles after which `starve_o[i]` asserts; legal range 1..255.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `m_req_i` in `NR_MASTER_PORTS`: per-master request.
- `m_add_i` in `NR_MASTER_PORTS`x32: byte address.
- `m_wen_i` in `NR_MASTER_PORTS`: write enable, active-low (1 = read).
- `m_wdata_i` in `NR_MASTER_PORTS`x32: write data.
- `m_be_i` in `NR_MASTER_PORTS`x4: byte enables.
- `m_gnt_o` out `NR_MASTER_PORTS`: per-master grant.
- `m_r_valid_o` out `NR_MASTER_PORTS`: per-master response valid.
- `m_r_rdata_o` out 32: response data, broadcast to all masters.
- `m_r_opc_o` out 1: response error flag, broadcast to all masters.
- `s_req_o`, `s_add_o`[32], `s_wen_o`, `s_wdata_o`[32], `s_be_o`[4] out: request to the slave.
- `s_gnt_i` in 1: slave grant.
- `s_r_valid_i` in 1, `s_r_rdata_i` in 32, `s_r_opc_i` in 1: slave response.
- `starve_o` out `NR_MASTER_PORTS`: wait counter of master i has reached `STARVE_THRESH`.
- `resp_err_o` out 1: sticky flag, set when `s_r_valid_i` arrives with no response pending.

## Operation
- **Request path (combinational):**
  - `sel` is the first index i with `m_req_i[i]=1`, searching upward from `rr_ptr` and wrapping modulo `NR_MASTER_PORTS`.
  - `s_req_o = |m_req_i`.
  - `s_add_o`, `s_wen_o`, `s_wdata_o` and `s_be_o` are muxed from `sel`. When no master requests they are 0.
  - `m_gnt_o[sel] = s_gnt_i & s_req_o`. All other grants are 0.
- **Handshake:** a transfer happens in a cycle with `s_req_o & s_gnt_i`. Masters hold request and payload stable until granted. The arbiter never drops or reorders a granted request.
- **Pointer:**
  - On each handshake, `rr_ptr <= (sel+1) mod NR_MASTER_PORTS`.
  - With no handshake, `rr_ptr` holds. A stalled slave does not rotate priority.
- **Response routing:**
  - On a handshake, register `pend_valid <= 1` and `pend_id <= sel`. Otherwise `pend_valid <= 0`.
  - In the next cycle, `m_r_valid_o[pend_id] = pend_valid & s_r_valid_i`.
  - `m_r_rdata_o` and `m_r_opc_o` pass through `s_r_rdata_i` and `s_r_opc_i` unmodified.
  - Reads and writes both return a response.
- **Error detection:** `s_r_valid_i=1` while `pend_valid=0` sets `resp_err_o`, and no master sees valid. `resp_err_o` is cleared only by reset.
- **Starvation counters:**
  - `wait_cnt[i]` is 8 bits.
  - It increments when `m_req_i[i] & ~m_gnt_o[i]` and saturates at 255.
  - It clears to 0 on a grant to i, or in any cycle where `m_req_i[i]=0`.
  - `starve_o[i] = (wait_cnt[i] >= STARVE_THRESH)`, registered.
  - Starvation is reporting only; it does not change arbitration.
- **Reset:**
  - While `rst_i=1`, force all outputs low: `s_req_o=0`, all `m_gnt_o=0`, all `m_r_valid_o=0`.
  - In the cycle after `rst_i` deasserts: `rr_ptr=0`, `pend_valid=0`, `pend_id=0`, all `wait_cnt=0`, `starve_o=0`, `resp_err_o=0`.
  - A response due in the cycle reset asserts is dropped.

## Timing
- Request to grant: 0 cycles (combinational) when the slave grants in the same cycle.
- Grant to `m_r_valid_o`: exactly 1 cycle.
- Throughput: 1 transfer per cycle. Back-to-back grants to different masters are allowed. Consecutive grants to the same master happen only when no other master requests.
- Worst-case wait with a slave that always grants: `NR_MASTER_PORTS-1` cycles.
- Simultaneous response for transfer N and handshake for transfer N+1 in the same cycle: both are handled. `pend_*` is overwritten with N+1's id after N's valid is routed.
- `starve_o` lags `wait_cnt` by 1 cycle.
- Register outputs: `starve_o`, `resp_err_o`.
- Combinational outputs: `m_gnt_o`, `s_*_o`, `m_r_*_o`.
- No combinational path from `s_r_*` to `s_req_o`.

## Test plan
- **Reset values:** assert `rst_i` for 3 cycles with all `m_req_i=1` → all grants 0, `s_req_o=0`. After release, the first grant goes to master 0 and `rr_ptr` becomes 1.
- **Round-robin fairness:** `NR_MASTER_PORTS=4`, all masters request continuously, `s_gnt_i=1` → grant order 0,1,2,3,0,1…; each `m_r_valid_o[i]` pulses exactly 1 cycle after its grant; `m_r_rdata_o` equals the slave model data.
- **Stalled slave:** masters 1 and 3 request, `s_gnt_i=0` for 70 cycles → no grants, `rr_ptr` unchanged, `starve_o[1]` and `starve_o[3]` assert after 64 wait cycles (+1 registered). Then set `s_gnt_i=1` → master 1 is granted first, then master 3, and counters clear.
- **Payload mux:** master 2 writes `add=0x1C000010`, `wdata=0xDEADBEEF`, `be=4'b0101`, `wen=0` → slave port sees identical fields; write response `opc=1` is routed only to master 2.
- **Pointer skip and wrap:** only master 3 requests, then only master 0 → both granted with no idle cycle; `rr_ptr` goes 3→0→1.
- **Spurious response:** drive `s_r_valid_i=1` with no pending transfer → `resp_err_o=1` next cycle and stays set; all `m_r_valid_o` stay 0; reset clears it.
